mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-master (instruction fetch / data) arbiter in front of a single
//            RAM port, with wait-cycle timeout and a sticky fault flag.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        ihit,
    output logic        dhit,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        mem_err
);

    localparam logic [1:0] c_ram_access = 2'd2;
    localparam logic [1:0] c_ram_error  = 2'd3;
    localparam logic [4:0] c_timeout    = 5'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DACC = 2'd1,
        ST_IACC = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_d_q, last_d_d;   // 1 when the most recent completed access was data
    logic        err_q, err_d;

    logic        w_dreq;
    logic        w_own_req;
    logic        w_hit;
    logic [4:0]  w_cnt_inc;

    assign w_dreq  = dREN | dWEN;
    assign mem_err = err_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            last_d_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_d_q <= last_d_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d_d  = last_d_q;
        err_d     = err_q;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = 32'd0;
        ramstore  = 32'd0;
        ihit      = 1'b0;
        dhit      = 1'b0;
        iload     = 32'd0;
        dload     = 32'd0;
        w_own_req = 1'b0;
        w_hit     = 1'b0;
        w_cnt_inc = {1'b0, cnt_q} + 5'd1;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = 4'd0;
                // A fetch that lost the previous round wins over a pending data request.
                if (iREN && last_d_q) begin
                    state_d = ST_IACC;
                end else if (w_dreq) begin
                    state_d = ST_DACC;
                end else if (iREN) begin
                    state_d = ST_IACC;
                end
            end
            ST_DACC: begin
                ramaddr   = daddr;
                ramstore  = dstore;
                ramWEN    = dWEN;
                ramREN    = dREN & ~dWEN;
                w_own_req = w_dreq;
            end
            ST_IACC: begin
                ramaddr   = iaddr;
                ramREN    = 1'b1;
                w_own_req = iREN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_q != ST_IDLE) begin
            if (!w_own_req) begin
                state_d = ST_IDLE;
            end else if (ramstate == c_ram_error) begin
                state_d = ST_IDLE;
                err_d   = 1'b1;
            end else if (ramstate == c_ram_access) begin
                state_d  = ST_IDLE;
                w_hit    = 1'b1;
                last_d_d = (state_q == ST_DACC);
            end else if (w_cnt_inc >= c_timeout) begin
                state_d = ST_IDLE;
                err_d   = 1'b1;
            end else begin
                cnt_d = w_cnt_inc[3:0];
            end
        end

        dhit  = w_hit && (state_q == ST_DACC);
        ihit  = w_hit && (state_q == ST_IACC);
        dload = dhit ? ramload : 32'd0;
        iload = ihit ? ramload : 32'd0;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter: directed scenarios plus
//            randomized traffic checked against an ownership-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int         TO        = 15;
    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;
    localparam int         OWN_NONE  = 0;
    localparam int         OWN_D     = 1;
    localparam int         OWN_I     = 2;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        iREN = 1'b0;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic [31:0] iaddr = 32'd0;
    logic [31:0] daddr = 32'd0;
    logic [31:0] dstore = 32'd0;
    logic [31:0] ramload = 32'd0;
    logic [1:0]  ramstate = 2'd0;
    logic        ihit, dhit, ramREN, ramWEN, mem_err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who currently owns the RAM, how long it has waited,
    // which side completed last, and whether a fault was ever seen.
    int m_owner;
    int m_waited;
    bit m_last_was_d;
    bit m_err;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .ihit     (ihit),
        .dhit     (dhit),
        .iload    (iload),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .mem_err  (mem_err)
    );

    always #5 CLK = ~CLK;

    function automatic logic [132:0] model_out();
        logic        e_ih, e_dh, e_ren, e_wen;
        logic [31:0] e_il, e_dl, e_a, e_s;
        e_ih = 1'b0; e_dh = 1'b0; e_ren = 1'b0; e_wen = 1'b0;
        e_il = 32'd0; e_dl = 32'd0; e_a = 32'd0; e_s = 32'd0;
        if (nRST && m_owner == OWN_D) begin
            e_a   = daddr;
            e_s   = dstore;
            e_wen = dWEN;
            e_ren = dREN & ~dWEN;
            if ((dREN || dWEN) && ramstate == RS_ACCESS) begin
                e_dh = 1'b1;
                e_dl = ramload;
            end
        end else if (nRST && m_owner == OWN_I) begin
            e_a   = iaddr;
            e_ren = 1'b1;
            if (iREN && ramstate == RS_ACCESS) begin
                e_ih = 1'b1;
                e_il = ramload;
            end
        end
        return {e_ih, e_dh, e_il, e_dl, e_ren, e_wen, e_a, e_s, nRST & m_err};
    endfunction

    task automatic model_step();
        bit still_wants;
        if (m_owner == OWN_NONE) begin
            m_waited = 0;
            if (iREN && (m_last_was_d || !(dREN || dWEN)))
                m_owner = OWN_I;
            else if (dREN || dWEN)
                m_owner = OWN_D;
        end else begin
            still_wants = (m_owner == OWN_D) ? (dREN || dWEN) : iREN;
            if (!still_wants) begin
                m_owner = OWN_NONE;
            end else if (ramstate == RS_ERROR) begin
                m_err   = 1'b1;
                m_owner = OWN_NONE;
            end else if (ramstate == RS_ACCESS) begin
                m_last_was_d = (m_owner == OWN_D);
                m_owner      = OWN_NONE;
            end else begin
                m_waited = m_waited + 1;
                if (m_waited >= TO) begin
                    m_err   = 1'b1;
                    m_owner = OWN_NONE;
                end
            end
        end
    endtask

    task automatic do_reset();
        nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = RS_FREE;
        @(posedge CLK); #1;
        nRST = 1'b1;
        m_owner = OWN_NONE; m_waited = 0; m_last_was_d = 1'b0; m_err = 1'b0;
    endtask

    task automatic test_reset();
        nRST = 1'b0; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b1; ramstate = RS_ACCESS;
        iaddr = 32'h1111_1111; daddr = 32'h2222_2222; dstore = 32'h3333_3333;
        ramload = 32'hFFFF_FFFF;
        @(negedge CLK);
        n_checks++;
        if ({ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err} !== 133'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ihit=%b dhit=%b iload=%h dload=%h ren=%b wen=%b addr=%h store=%h err=%b, want all 0",
                     ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err);
        end
    endtask

    task automatic test_ifetch();
        int hits;
        hits = 0;
        do_reset();
        iaddr = 32'h40; ramload = 32'h8C01_0004;
        for (int c = 0; c < 7; c++) begin
            iREN     = (c <= 3);
            ramstate = (c == 3) ? RS_ACCESS : RS_BUSY;
            @(negedge CLK);
            if (ihit) hits++;
            if (c == 1) begin
                n_checks++;
                if (ramREN !== 1'b1 || ramaddr !== 32'h40 || ihit !== 1'b0 || iload !== 32'd0) begin
                    n_fail++;
                    $display("FAIL ifetch_wait: got ren=%b addr=%h ihit=%b iload=%h, want 1 00000040 0 00000000",
                             ramREN, ramaddr, ihit, iload);
                end
            end
            if (c == 3) begin
                n_checks++;
                if (ihit !== 1'b1 || iload !== 32'h8C01_0004 || ramREN !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ifetch_hit: got ihit=%b iload=%h ren=%b, want 1 8c010004 1", ihit, iload, ramREN);
                end
            end
            @(posedge CLK); #1;
        end
        n_checks++;
        if (hits != 1) begin
            n_fail++;
            $display("FAIL ifetch_hit_count: got %0d, want 1", hits);
        end
    endtask

    task automatic test_priority();
        do_reset();
        iREN = 1'b1; iaddr = 32'h80;
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
        ramload = 32'h1234_5678; ramstate = RS_ACCESS;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            if (c == 1) begin
                n_checks++;
                if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h100 || ramstore !== 32'hDEAD_BEEF
                    || dhit !== 1'b1 || dload !== 32'h1234_5678 || ihit !== 1'b0) begin
                    n_fail++;
                    $display("FAIL prio_data_first: got wen=%b ren=%b addr=%h store=%h dhit=%b dload=%h ihit=%b, want 1 0 00000100 deadbeef 1 12345678 0",
                             ramWEN, ramREN, ramaddr, ramstore, dhit, dload, ihit);
                end
            end
            if (c == 2) begin
                n_checks++;
                if (ramWEN !== 1'b0 || ramREN !== 1'b0 || dhit !== 1'b0 || ihit !== 1'b0) begin
                    n_fail++;
                    $display("FAIL prio_idle_gap: got wen=%b ren=%b dhit=%b ihit=%b, want 0 0 0 0", ramWEN, ramREN, dhit, ihit);
                end
            end
            if (c == 3) begin
                n_checks++;
                if (ihit !== 1'b1 || iload !== 32'h1234_5678 || ramaddr !== 32'h80 || ramWEN !== 1'b0
                    || ramstore !== 32'd0 || dhit !== 1'b0 || dload !== 32'd0) begin
                    n_fail++;
                    $display("FAIL prio_starvation_guard: got ihit=%b iload=%h addr=%h wen=%b store=%h dhit=%b dload=%h, want 1 12345678 00000080 0 0 0 0",
                             ihit, iload, ramaddr, ramWEN, ramstore, dhit, dload);
                end
            end
            if (c == 5) begin
                n_checks++;
                if (dhit !== 1'b1 || ihit !== 1'b0) begin
                    n_fail++;
                    $display("FAIL prio_data_again: got dhit=%b ihit=%b, want 1 0", dhit, ihit);
                end
            end
            @(posedge CLK); #1;
        end
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    endtask

    task automatic test_no_preempt();
        do_reset();
        iaddr = 32'h200; daddr = 32'h300; ramload = 32'hA5A5_0001;
        for (int c = 0; c < 6; c++) begin
            iREN     = (c <= 3);
            dREN     = (c >= 1);
            ramstate = (c == 3 || c == 5) ? RS_ACCESS : RS_BUSY;
            @(negedge CLK);
            if (c == 2) begin
                n_checks++;
                if (ramaddr !== 32'h200 || ramREN !== 1'b1 || dhit !== 1'b0 || ihit !== 1'b0) begin
                    n_fail++;
                    $display("FAIL nopreempt_hold: got addr=%h ren=%b dhit=%b ihit=%b, want 00000200 1 0 0", ramaddr, ramREN, dhit, ihit);
                end
            end
            if (c == 3) begin
                n_checks++;
                if (ihit !== 1'b1 || dhit !== 1'b0 || iload !== 32'hA5A5_0001) begin
                    n_fail++;
                    $display("FAIL nopreempt_ihit: got ihit=%b dhit=%b iload=%h, want 1 0 a5a50001", ihit, dhit, iload);
                end
            end
            if (c == 5) begin
                n_checks++;
                if (ramaddr !== 32'h300 || ramREN !== 1'b1 || dhit !== 1'b1 || dload !== 32'hA5A5_0001) begin
                    n_fail++;
                    $display("FAIL nopreempt_data_next: got addr=%h ren=%b dhit=%b dload=%h, want 00000300 1 1 a5a50001",
                             ramaddr, ramREN, dhit, dload);
                end
            end
            @(posedge CLK); #1;
        end
        dREN = 1'b0;
    endtask

    task automatic test_timeout();
        int dhits;
        dhits = 0;
        do_reset();
        dREN = 1'b1; daddr = 32'h44; ramload = 32'h0BAD_F00D; ramstate = RS_BUSY;
        for (int c = 0; c < 17; c++) begin
            @(negedge CLK);
            if (dhit) dhits++;
            if (c == 15) begin
                n_checks++;
                if (ramREN !== 1'b1 || mem_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL timeout_last_wait: got ren=%b err=%b, want 1 0", ramREN, mem_err);
                end
            end
            if (c == 16) begin
                n_checks++;
                if (ramREN !== 1'b0 || mem_err !== 1'b1) begin
                    n_fail++;
                    $display("FAIL timeout_abort: got ren=%b err=%b, want 0 1", ramREN, mem_err);
                end
            end
            @(posedge CLK); #1;
        end
        n_checks++;
        if (dhits != 0) begin
            n_fail++;
            $display("FAIL timeout_no_hit: got %0d hits, want 0", dhits);
        end
        ramstate = RS_ACCESS;
        @(negedge CLK);
        n_checks++;
        if (dhit !== 1'b1 || mem_err !== 1'b1 || dload !== 32'h0BAD_F00D) begin
            n_fail++;
            $display("FAIL timeout_continue: got dhit=%b err=%b dload=%h, want 1 1 0badf00d", dhit, mem_err, dload);
        end
        @(posedge CLK); #1;
        dREN = 1'b0;
        nRST = 1'b0;
        #1;
        n_checks++;
        if (mem_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_err_clear: got err=%b, want 0", mem_err);
        end
    endtask

    task automatic test_error();
        do_reset();
        dWEN = 1'b1; daddr = 32'h88; dstore = 32'h5555_AAAA; ramstate = RS_BUSY;
        @(posedge CLK); #1;
        ramstate = RS_ERROR;
        @(negedge CLK);
        n_checks++;
        if (ramWEN !== 1'b1 || dhit !== 1'b0 || mem_err !== 1'b0) begin
            n_fail++;
            $display("FAIL error_in_dacc: got wen=%b dhit=%b err=%b, want 1 0 0", ramWEN, dhit, mem_err);
        end
        @(posedge CLK); #1;
        dWEN = 1'b0; ramstate = RS_FREE;
        @(negedge CLK);
        n_checks++;
        if (ramWEN !== 1'b0 || dhit !== 1'b0 || mem_err !== 1'b1) begin
            n_fail++;
            $display("FAIL error_abort: got wen=%b dhit=%b err=%b, want 0 0 1", ramWEN, dhit, mem_err);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        iREN = 1'b1; iaddr = 32'h500; ramload = 32'h7777_0000; ramstate = RS_BUSY;
        @(posedge CLK); #1;
        @(negedge CLK);
        n_checks++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h500) begin
            n_fail++;
            $display("FAIL rstmid_before: got ren=%b addr=%h, want 1 00000500", ramREN, ramaddr);
        end
        #1;
        nRST = 1'b0; ramstate = RS_ACCESS;
        #1;
        n_checks++;
        if (ramREN !== 1'b0 || ihit !== 1'b0 || ramaddr !== 32'd0) begin
            n_fail++;
            $display("FAIL rstmid_async: got ren=%b ihit=%b addr=%h, want 0 0 0", ramREN, ihit, ramaddr);
        end
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(negedge CLK);
        n_checks++;
        if (ramREN !== 1'b0 || ihit !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_idle_after: got ren=%b ihit=%b, want 0 0", ramREN, ihit);
        end
        @(posedge CLK); #1;
        @(negedge CLK);
        n_checks++;
        if (ihit !== 1'b1 || iload !== 32'h7777_0000) begin
            n_fail++;
            $display("FAIL rstmid_resume: got ihit=%b iload=%h, want 1 77770000", ihit, iload);
        end
        @(posedge CLK); #1;
        iREN = 1'b0;
    endtask

    task automatic test_random(input int cycles, input int access_pct);
        logic [132:0] exp_v;
        logic [132:0] act_v;
        do_reset();
        for (int c = 0; c < cycles; c++) begin
            int r;
            if ($urandom_range(0, 7) == 0) iREN = ~iREN;
            if ($urandom_range(0, 7) == 0) dREN = ~dREN;
            if ($urandom_range(0, 9) == 0) dWEN = ~dWEN;
            iaddr   = $urandom;
            daddr   = $urandom;
            dstore  = $urandom;
            ramload = $urandom;
            r = int'($urandom_range(0, 99));
            if (r < 2)                   ramstate = RS_ERROR;
            else if (r < 2 + access_pct) ramstate = RS_ACCESS;
            else if (r < 90)             ramstate = RS_BUSY;
            else                         ramstate = RS_FREE;
            @(negedge CLK);
            exp_v = model_out();
            act_v = {ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL random[%0d] {ihit,dhit,iload,dload,ren,wen,addr,store,err}: got %h, want %h", c, act_v, exp_v);
            end
            @(posedge CLK);
            model_step();
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ifetch();
        test_priority();
        test_no_preempt();
        test_timeout();
        test_error();
        test_reset_mid_access();
        test_random(300, 30);
        test_random(300, 4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
